// File: rtl/blink_mon_pkg.sv
// Shared constants and state encoding for the blink period monitor and its divider counterpart.
package blink_mon_pkg;

  localparam int CLK_HZ     = 20000000;
  localparam int DIV_RELOAD = 2000000;
  localparam int EXPECT_DEF = DIV_RELOAD + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous input with a both-edges detect pulse.
module sync_edge_detect
  import blink_mon_pkg::*;
(
  input  logic CLK20MHZ,
  input  logic RESET,
  input  logic din,
  output logic sig_edge
);

  logic s1, s2, s3;

  always_ff @(posedge CLK20MHZ) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge = s2 ^ s3;

endmodule

// File: rtl/blink_period_monitor.sv
// Measures edge-to-edge intervals of an async toggling input, tracks lock against
// an expected interval and flags loss of toggling.
module blink_period_monitor
  import blink_mon_pkg::*;
#(
  parameter int CNT_W       = 22,
  parameter int EXPECT      = EXPECT_DEF,
  parameter int TOL         = 1000,
  parameter int TIMEOUT_CYC = 4000000,
  parameter int LOCK_N      = 4
) (
  input  logic             CLK20MHZ,
  input  logic             RESET,
  input  logic             SIGIN,
  output logic [CNT_W-1:0] HALF_PERIOD,
  output logic             VALID,
  output logic             IN_TOL,
  output logic             LOCKED,
  output logic             TIMEOUT
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0]    EXP_V  = (CNT_W+1)'(EXPECT);
  localparam logic [CNT_W:0]    TOL_V  = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0]  TO_V   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  TO_M1  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_N);

  logic              sig_edge;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [CNT_W:0]    meas;
  logic [CNT_W:0]    dev;
  logic              in_tol;
  logic              hit_to;
  logic [GOOD_W-1:0] good_nxt;

  sync_edge_detect u_sync (
    .CLK20MHZ (CLK20MHZ),
    .RESET    (RESET),
    .din      (SIGIN),
    .sig_edge (sig_edge)
  );

  always_comb begin
    meas     = {1'b0, cnt} + (CNT_W+1)'(1);
    dev      = (meas >= EXP_V) ? (meas - EXP_V) : (EXP_V - meas);
    in_tol   = (dev <= TOL_V);
    // Timeout fires on the clock where cnt lands on TIMEOUT_CYC, so an edge
    // in that same cycle wins and no timeout is raised.
    hit_to   = !sig_edge && (cnt >= TO_M1);
    good_nxt = '0;
    if (in_tol) good_nxt = (good_cnt == LOCK_V) ? good_cnt : good_cnt + 1'b1;
  end

  always_ff @(posedge CLK20MHZ) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      good_cnt    <= '0;
      HALF_PERIOD <= '0;
      VALID       <= 1'b0;
      IN_TOL      <= 1'b0;
      LOCKED      <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      VALID <= 1'b0;

      if (sig_edge)         cnt <= '0;
      else if (cnt < TO_V)  cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (sig_edge) begin
            state <= MEAS;
          end else if (hit_to) begin
            state   <= STALL;
            TIMEOUT <= 1'b1;
          end
        end
        MEAS: begin
          if (sig_edge) begin
            HALF_PERIOD <= meas[CNT_W-1:0];
            VALID       <= 1'b1;
            IN_TOL      <= in_tol;
            good_cnt    <= good_nxt;
            LOCKED      <= (good_nxt == LOCK_V);
          end else if (hit_to) begin
            state    <= STALL;
            TIMEOUT  <= 1'b1;
            LOCKED   <= 1'b0;
            good_cnt <= '0;
          end
        end
        STALL: begin
          if (sig_edge) begin
            state   <= MEAS;
            TIMEOUT <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
